// File: rtl/lfsr_rng_stream.sv
// Maximal-length Galois LFSR random source on a valid/ready stream, with
// runtime reseed, gated generation and period-completion detection.
module lfsr_rng_stream #(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] SEED  = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    seed_load,
  input  logic [WIDTH-1:0]        seed_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] rand_out,
  output logic [WIDTH-1:0]        sample_cnt,
  output logic                    period_done
);

  generate
    if (!(WIDTH == 8 || WIDTH == 16 || WIDTH == 24 || WIDTH == 32)) begin : g_bad_width
      $error("lfsr_rng_stream: WIDTH must be 8, 16, 24 or 32");
    end
  endgenerate

  localparam logic [31:0] MASK32 = (WIDTH == 8)  ? 32'h0000_00B8 :
                                   (WIDTH == 16) ? 32'h0000_B400 :
                                   (WIDTH == 24) ? 32'h00E1_0000 :
                                                   32'hA300_0000;
  localparam logic [WIDTH-1:0] MASK     = MASK32[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] SEED_EFF = (SEED == '0) ? ONE : SEED;

  logic [WIDTH-1:0] state;
  logic [WIDTH-1:0] start_seed;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] load_val;
  logic             fire;

  always_comb begin
    nxt      = (state >> 1) ^ (state[0] ? MASK : '0);
    load_val = (seed_in == '0) ? ONE : seed_in;
    fire     = out_valid & out_ready;
  end

  assign rand_out = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= SEED_EFF;
      start_seed  <= SEED_EFF;
      out_valid   <= 1'b0;
      sample_cnt  <= '0;
      period_done <= 1'b0;
    end else if (seed_load) begin
      // A load overrides any concurrent handshake; the fired sample is simply dropped.
      state       <= load_val;
      start_seed  <= load_val;
      out_valid   <= en;
      sample_cnt  <= '0;
      period_done <= 1'b0;
    end else begin
      period_done <= 1'b0;
      if (fire) begin
        state     <= nxt;
        out_valid <= en;
        if (nxt == start_seed) begin
          period_done <= 1'b1;
          sample_cnt  <= '0;
        end else begin
          sample_cnt <= sample_cnt + ONE;
        end
      end else if (!out_valid) begin
        out_valid <= en;
      end
    end
  end

endmodule
